alu_sched: RTL and testbench

//  Two-requester scheduler for the CPU's shared synchronous ALU (registered A/F wrapper).

---
 rtl/alu_sched_pkg.sv | 11 +
 rtl/alu_rr_arb2.sv | 13 +
 rtl/alu_sched.sv | 131 +++++++++++++
 tb/tb_alu_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared constants, FSM state and port index type for the ALU scheduler
package alu_sched_pkg;
    localparam int OP_W   = 5;
    localparam int DATA_W = 16;
    localparam int FLAG_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    typedef logic port_t;
endpackage

// File: rtl/alu_rr_arb2.sv
// alu_rr_arb2: two-way round-robin arbiter; on a tie the port that did not win last time is picked
module alu_rr_arb2
    import alu_sched_pkg::*;
(
    input  logic [1:0] valid_i,
    input  port_t      last_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output port_t      idx_o
);
    assign idx_o   = &valid_i ? ~last_i : valid_i[1];
    assign grant_o = (en_i && |valid_i) ? (idx_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sequencing one shared-ALU operation per request (IDLE/ISSUE/CAPTURE/RESP)
// Optional grant counters enabled by ALU_SCHED_PERF_EN.
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int OP_W   = alu_sched_pkg::OP_W,
    parameter int DATA_W = alu_sched_pkg::DATA_W,
    parameter int FLAG_W = alu_sched_pkg::FLAG_W,
    parameter int CNT_W  = alu_sched_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_x,
    input  logic [2*DATA_W-1:0] req_y,
    input  logic [1:0]          req_wa,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_port,
    output logic [DATA_W-1:0]   resp_a,
    output logic [FLAG_W-1:0]   resp_f,
    output logic [OP_W-1:0]     alu_op,
    output logic [DATA_W-1:0]   alu_x,
    output logic [DATA_W-1:0]   alu_y,
    output logic                alu_enable,
    output logic                alu_writeA,
    input  logic [DATA_W-1:0]   alu_a,
    input  logic [FLAG_W-1:0]   alu_f,
    input  logic                perf_clr,
    output logic [CNT_W-1:0]    perf_cnt0,
    output logic [CNT_W-1:0]    perf_cnt1
);
    state_e              state_q, state_d;
    port_t               last_q, gnt_idx;
    logic [1:0]          gnt;
    logic                accept;
    logic [OP_W-1:0]     alu_op_q;
    logic [DATA_W-1:0]   alu_x_q, alu_y_q, resp_a_q;
    logic [FLAG_W-1:0]   resp_f_q;
    logic                alu_en_q, alu_wa_q, resp_port_q;

    alu_rr_arb2 u_arb (
        .valid_i (req_valid),
        .last_i  (last_q),
        .en_i    (state_q == IDLE),
        .grant_o (gnt),
        .idx_o   (gnt_idx)
    );

    assign accept    = |gnt;
    assign req_ready = gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ISSUE : IDLE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // The issue registers double as the request latch: loaded on accept, held until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            alu_op_q    <= '0;
            alu_x_q     <= '0;
            alu_y_q     <= '0;
            alu_en_q    <= 1'b0;
            alu_wa_q    <= 1'b0;
            resp_a_q    <= '0;
            resp_f_q    <= '0;
            resp_port_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_en_q <= accept;
            alu_wa_q <= accept && req_wa[gnt_idx];
            if (accept) begin
                last_q   <= gnt_idx;
                alu_op_q <= gnt_idx ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
                alu_x_q  <= gnt_idx ? req_x[2*DATA_W-1:DATA_W]  : req_x[DATA_W-1:0];
                alu_y_q  <= gnt_idx ? req_y[2*DATA_W-1:DATA_W]  : req_y[DATA_W-1:0];
            end
            if (state_q == CAPTURE) begin
                resp_a_q    <= alu_a;
                resp_f_q    <= alu_f;
                resp_port_q <= last_q;
            end
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_x      = alu_x_q;
    assign alu_y      = alu_y_q;
    assign alu_enable = alu_en_q;
    assign alu_writeA = alu_wa_q;
    assign resp_valid = (state_q == RESP);
    assign resp_port  = resp_port_q;
    assign resp_a     = resp_a_q;
    assign resp_f     = resp_f_q;

`ifdef ALU_SCHED_PERF_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (perf_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + 1'b1;
            if (gnt[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign perf_cnt0 = cnt0_q;
    assign perf_cnt1 = cnt1_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_cnt0 = '0;
    assign perf_cnt1 = '0;
`endif
endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: randomized + directed self-checking bench for alu_sched against a transaction-level model
module tb_alu_sched;
`ifdef ALU_SCHED_PERF_EN
    localparam int CNT_W = 3;
`else
    localparam int CNT_W = 16;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0, req_wa = '0, req_ready;
    logic [9:0]  req_op = '0;
    logic [31:0] req_x = '0, req_y = '0;
    logic        resp_ready = 1'b0, perf_clr = 1'b0;
    logic        resp_valid, resp_port, alu_enable, alu_writeA;
    logic [15:0] resp_a, alu_x, alu_y;
    logic [7:0]  resp_f;
    logic [4:0]  alu_op;
    logic [15:0] alu_a_r = '0;
    logic [7:0]  alu_f_r = '0;
    logic [CNT_W-1:0] perf_cnt0, perf_cnt1;

    int tests = 0, fails = 0;

    alu_sched #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_wa(req_wa),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_port(resp_port), .resp_a(resp_a), .resp_f(resp_f),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_enable(alu_enable), .alu_writeA(alu_writeA),
        .alu_a(alu_a_r), .alu_f(alu_f_r),
        .perf_clr(perf_clr), .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
    );

    always #5 clk = ~clk;

    // ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others pass X; bit16 is carry/borrow
    function automatic logic [16:0] alu_calc(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            5'd0: return {1'b0, x} + {1'b0, y};
            5'd1: return {1'b0, x} - {1'b0, y};
            5'd2: return {1'b0, x & y};
            5'd3: return {1'b0, x | y};
            5'd4: return {1'b0, x ^ y};
            default: return {1'b0, x};
        endcase
    endfunction

    function automatic logic [7:0] flags(input logic [16:0] r);
        return {5'b0, r[16], r[15], r[15:0] == 16'h0};
    endfunction

    function automatic logic [15:0] res16(input logic [16:0] r);
        return r[15:0];
    endfunction

    // Registered ALU wrapper: F written on every enable, A only with writeA.
    always @(posedge clk) begin
        if (alu_enable) begin
            alu_f_r <= flags(alu_calc(alu_op, alu_x, alu_y));
            if (alu_writeA) alu_a_r <= res16(alu_calc(alu_op, alu_x, alu_y));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: age = cycles since accept (0 = free), result stored when the op completes.
    int          m_age = 0;
    logic        m_last = 1'b1, m_wa = 1'b0, m_port = 1'b0, m_rp = 1'b0, m_pp = 1'b0;
    logic [4:0]  m_iop = '0;
    logic [15:0] m_ix = '0, m_iy = '0, m_A = '0, m_ra = '0, m_pa = '0;
    logic [7:0]  m_rf = '0, m_pf = '0;
    logic [CNT_W-1:0] m_c0 = '0, m_c1 = '0;
    localparam logic [CNT_W-1:0] CMAX = '1;

    always @(negedge clk) begin
        logic [1:0] e_ready;
        logic g;
        logic [16:0] r;
        if (reset) begin
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_alu_enable", alu_enable, 0);
            chk("rst_alu_writeA", alu_writeA, 0);
            chk("rst_alu_op", alu_op, 0);
            chk("rst_resp_a", resp_a, 0);
            chk("rst_perf", {perf_cnt1, perf_cnt0}, 0);
            m_age = 0; m_last = 1'b1; m_iop = '0; m_ix = '0; m_iy = '0;
            m_ra = '0; m_rf = '0; m_rp = 1'b0; m_c0 = '0; m_c1 = '0;
        end else begin
            e_ready = 2'b00;
            g = 1'b0;
            if (m_age == 0 && req_valid != 2'b00) begin
                g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                e_ready = 2'b01 << g;
            end
            chk("req_ready", req_ready, e_ready);
            chk("alu_enable", alu_enable, m_age == 1);
            chk("alu_writeA", alu_writeA, m_age == 1 && m_wa);
            chk("alu_op", alu_op, m_iop);
            chk("alu_xy", {alu_x, alu_y}, {m_ix, m_iy});
            chk("resp_valid", resp_valid, m_age == 3);
            chk("resp_fields", {resp_port, resp_f, resp_a}, {m_rp, m_rf, m_ra});
            chk("perf_cnt", {perf_cnt1, perf_cnt0}, {m_c1, m_c0});
`ifdef ALU_SCHED_PERF_EN
            if (perf_clr) begin
                m_c0 = '0; m_c1 = '0;
            end else begin
                if (e_ready[0] && m_c0 != CMAX) m_c0 = m_c0 + 1'b1;
                if (e_ready[1] && m_c1 != CMAX) m_c1 = m_c1 + 1'b1;
            end
`endif
            if (m_age == 0) begin
                if (e_ready != 2'b00) begin
                    m_last = g; m_port = g; m_wa = req_wa[g];
                    m_iop = g ? req_op[9:5] : req_op[4:0];
                    m_ix  = g ? req_x[31:16] : req_x[15:0];
                    m_iy  = g ? req_y[31:16] : req_y[15:0];
                    m_age = 1;
                end
            end else if (m_age == 1) begin
                r = alu_calc(m_iop, m_ix, m_iy);
                if (m_wa) m_A = r[15:0];
                m_pa = m_A; m_pf = flags(r); m_pp = m_port;
                m_age = 2;
            end else if (m_age == 2) begin
                m_ra = m_pa; m_rf = m_pf; m_rp = m_pp;
                m_age = 3;
            end else if (resp_ready) begin
                m_age = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int p, input logic [4:0] op, input logic [15:0] x, input logic [15:0] y, input logic wa);
        int n;
        req_op[p*5 +: 5] = op;
        req_x[p*16 +: 16] = x;
        req_y[p*16 +: 16] = y;
        req_wa[p] = wa;
        req_valid = 2'b01 << p;
        resp_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready[p] && n < 20) begin tick(); n++; end
        chk("do_op_accept", req_ready[p], 1);
        tick();
        req_valid = 2'b00;
        n = 0;
        while (!resp_valid && n < 20) begin tick(); n++; end
        chk("do_op_resp", resp_valid, 1);
        tick();
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // port 0 ADD 0x12+0x34, writeA, consumer stalls for 5 cycles
        req_op[4:0] = 5'd0; req_x[15:0] = 16'h0012; req_y[15:0] = 16'h0034; req_wa = 2'b01;
        req_valid = 2'b01; resp_ready = 1'b0;
        #1 chk("t0_ready", req_ready, 2'b01);
        tick(); req_valid = 2'b00;
        chk("t1_enable", {alu_enable, alu_writeA}, 2'b11);
        tick(); chk("t2_idle", {alu_enable, resp_valid}, 2'b00);
        tick(); chk("t3_resp", {resp_valid, resp_port}, 2'b10);
        chk("t3_resp_a", resp_a, 16'h0046);
        chk("t3_resp_f", resp_f, 8'h00);
        req_valid = 2'b11;
        repeat (5) begin
            tick();
            chk("hold_resp", {resp_valid, resp_a}, {1'b1, 16'h0046});
            chk("hold_ready", req_ready, 2'b00);
            chk("hold_enable", alu_enable, 0);
        end
        req_valid = 2'b00; resp_ready = 1'b1;
        tick();

        // port 1 XOR without writeA: A stays, F reports zero result
        req_op[9:5] = 5'd4; req_x[31:16] = 16'h00FF; req_y[31:16] = 16'h00FF; req_wa = 2'b00;
        req_valid = 2'b10;
        #1 chk("wa0_ready", req_ready, 2'b10);
        tick(); req_valid = 2'b00;
        chk("wa0_issue", {alu_enable, alu_writeA}, 2'b10);
        tick(); tick();
        chk("wa0_resp", {resp_valid, resp_port}, 2'b11);
        chk("wa0_resp_a", resp_a, 16'h0046);
        chk("wa0_resp_f", resp_f, 8'h01);
        tick();

        // reset in ISSUE aborts the op; the first tie afterwards goes to port 0
        req_op[9:5] = 5'd0; req_x[31:16] = 16'h1111; req_wa = 2'b10; req_valid = 2'b10;
        #1 chk("rst_case_ready", req_ready, 2'b10);
        tick();
        chk("rst_case_issue", alu_enable, 1);
        reset = 1'b1; req_valid = 2'b00;
        #1 chk("rst_async", {alu_enable, alu_writeA, resp_valid, alu_op, alu_x}, 0);
        tick(); tick();
        reset = 1'b0; req_valid = 2'b11;
        #1 chk("post_rst_grant", req_ready, 2'b01);

        // continuous contention alternates 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin tick(); n++; end
            chk("alt_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            tick();
        end
        req_valid = 2'b00;
        repeat (6) tick();

`ifdef ALU_SCHED_PERF_EN
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
        chk("perf_clr0", {perf_cnt1, perf_cnt0}, 0);
        repeat (3) do_op(0, 5'd0, 16'h0001, 16'h0002, 1'b1);
        repeat (2) do_op(1, 5'd1, 16'h0005, 16'h0003, 1'b0);
        chk("perf_cnt0_3", perf_cnt0, 3);
        chk("perf_cnt1_2", perf_cnt1, 2);
        perf_clr = 1'b1; tick(); perf_clr = 1'b0;
        chk("perf_clr1", {perf_cnt1, perf_cnt0}, 0);
        repeat (9) do_op(0, 5'd3, 16'h00F0, 16'h000F, 1'b1);
        chk("perf_sat", perf_cnt0, {CNT_W{1'b1}});
`else
        do_op(0, 5'd1, 16'h0000, 16'h0001, 1'b1);
        chk("sub_borrow_a", resp_a, 16'hFFFF);
        chk("sub_borrow_f", resp_f, 8'h06);
`endif

        // randomized traffic checked cycle by cycle by the model
        repeat (3000) begin
            req_valid  = 2'($urandom_range(0, 3));
            req_op     = 10'($urandom);
            req_x      = $urandom;
            req_y      = $urandom;
            req_wa     = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 3) != 0);
            perf_clr   = ($urandom_range(0, 39) == 0);
            tick();
        end
        req_valid = 2'b00; perf_clr = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
